// File: rtl/video_pkg.sv
// video_pkg: shared coordinate width, standard timing sets and the axis-total helper.
package video_pkg;
    localparam int COORD_W = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_timing_t;
    localparam axis_timing_t ST_MONO_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam axis_timing_t ST_MONO_V = '{active: 16'd400, fp: 16'd12, sync: 16'd2, bp: 16'd35};
    // Colour mode: 320 pixels at half rate, 200 lines each shown twice.
    localparam axis_timing_t ST_COLOUR_H = '{active: 16'd320, fp: 16'd8, sync: 16'd48, bp: 16'd24};
    localparam axis_timing_t ST_COLOUR_V = '{active: 16'd400, fp: 16'd12, sync: 16'd2, bp: 16'd35};
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
endpackage

// File: rtl/video_timing_gen_sync_axis_counter.sv
// sync_axis_counter: one raster axis counter with active and sync region decode.
module sync_axis_counter
    import video_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP = 16,
    parameter int SYNC = 96,
    parameter int BP = 48
) (
    input  logic               pclk,
    input  logic               reset_n,
    input  logic               step,
    output logic [COORD_W-1:0] cnt,
    output logic               last,
    output logic               in_active,
    output logic               in_sync
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] LAST = CW1'(TOTAL - 1);
    localparam logic [CW1-1:0] A_END = CW1'(ACTIVE);
    localparam logic [CW1-1:0] S_BEG = CW1'(ACTIVE + FP);
    localparam logic [CW1-1:0] S_END = CW1'(ACTIVE + FP + SYNC);
    if (TOTAL > MAX_TOTAL || TOTAL < 1) begin : g_bad_total
        $error("sync_axis_counter: axis total %0d outside 1..%0d", TOTAL, MAX_TOTAL);
    end
    logic [CW1-1:0] cnt_x;
    assign cnt_x = {1'b0, cnt};
    assign last = cnt_x == LAST;
    assign in_active = cnt_x < A_END;
    assign in_sync = cnt_x >= S_BEG && cnt_x < S_END;
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (step) cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source with sync polarity switched only at frame boundaries.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = int'(ST_MONO_H.active),
    parameter int H_FP = int'(ST_MONO_H.fp),
    parameter int H_SYNC = int'(ST_MONO_H.sync),
    parameter int H_BP = int'(ST_MONO_H.bp),
    parameter int V_ACTIVE = int'(ST_MONO_V.active),
    parameter int V_FP = int'(ST_MONO_V.fp),
    parameter int V_SYNC = int'(ST_MONO_V.sync),
    parameter int V_BP = int'(ST_MONO_V.bp)
) (
    input  logic               pclk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               hs_pol,
    input  logic               vs_pol,
    output logic               hs_out,
    output logic               vs_out,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               sol,
    output logic               sof,
    output logic               pol_ack
);
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic h_last, v_last, h_act, v_act, h_sync, v_sync;
    logic hs_pol_q, vs_pol_q, pol_chg, act, frame_wrap;
    assign act = h_act && v_act;
    assign frame_wrap = enable && h_last && v_last;
    sync_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .pclk(pclk), .reset_n(reset_n), .step(enable), .cnt(h_cnt),
        .last(h_last), .in_active(h_act), .in_sync(h_sync)
    );
    sync_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .pclk(pclk), .reset_n(reset_n), .step(enable && h_last), .cnt(v_cnt),
        .last(v_last), .in_active(v_act), .in_sync(v_sync)
    );
    // Shadows load with the counters' wrap, so the (0,0) outputs already use them.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs_pol_q <= 1'b0;
            vs_pol_q <= 1'b0;
            pol_chg <= 1'b0;
        end else if (enable) begin
            pol_chg <= frame_wrap && (hs_pol != hs_pol_q || vs_pol != vs_pol_q);
            if (frame_wrap) begin
                hs_pol_q <= hs_pol;
                vs_pol_q <= vs_pol;
            end
        end
    end
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs_out <= 1'b1;
            vs_out <= 1'b1;
            de <= 1'b0;
            x <= '0;
            y <= '0;
            sol <= 1'b0;
            sof <= 1'b0;
            pol_ack <= 1'b0;
        end else begin
            sol <= enable && h_cnt == '0;
            sof <= enable && h_cnt == '0 && v_cnt == '0;
            pol_ack <= enable && pol_chg;
            if (enable) begin
                hs_out <= h_sync ? hs_pol_q : ~hs_pol_q;
                vs_out <= v_sync ? vs_pol_q : ~vs_pol_q;
                de <= act;
                x <= act ? h_cnt : '0;
                y <= act ? v_cnt : '0;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed and random checks of video_timing_gen against a frame-position model.
module tb_video_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    logic pclk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic hs_pol = 1'b0;
    logic vs_pol = 1'b0;
    logic s_hs, s_vs, s_de, s_sol, s_sof, s_ack;
    logic [9:0] s_x, s_y;
    logic d_hs, d_vs, d_de, d_sol, d_sof, d_ack;
    logic [9:0] d_x, d_y;
    int checks = 0;
    int failures = 0;
    int m_pos;
    logic m_hp, m_vp, m_pend;
    logic e_hs, e_vs, e_de, e_sol, e_sof, e_ack;
    logic [9:0] e_x, e_y;

    always #5 pclk = ~pclk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_s (
        .pclk(pclk), .reset_n(reset_n), .enable(enable), .hs_pol(hs_pol), .vs_pol(vs_pol),
        .hs_out(s_hs), .vs_out(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .sol(s_sol), .sof(s_sof), .pol_ack(s_ack)
    );

    video_timing_gen u_d (
        .pclk(pclk), .reset_n(reset_n), .enable(enable), .hs_pol(hs_pol), .vs_pol(vs_pol),
        .hs_out(d_hs), .vs_out(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .sol(d_sol), .sof(d_sof), .pol_ack(d_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_hp = 0; m_vp = 0; m_pend = 0;
        e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_sol = 0; e_sof = 0; e_ack = 0;
    endtask

    // Model tracks the linear position within the frame; h and v follow from it.
    task automatic model_step();
        int h, v;
        e_sol = 0; e_sof = 0; e_ack = 0;
        if (!enable) return;
        h = m_pos % HT;
        v = m_pos / HT;
        e_hs = (h >= HA + HF && h < HA + HF + HS) ? m_hp : !m_hp;
        e_vs = (v >= VA + VF && v < VA + VF + VS) ? m_vp : !m_vp;
        e_de = h < HA && v < VA;
        e_x = e_de ? 10'(h) : 10'd0;
        e_y = e_de ? 10'(v) : 10'd0;
        e_sol = h == 0;
        e_sof = m_pos == 0;
        e_ack = m_pend;
        m_pend = 0;
        if (m_pos == FT - 1) begin
            m_pend = hs_pol != m_hp || vs_pol != m_vp;
            m_hp = hs_pol;
            m_vp = vs_pol;
        end
        m_pos = (m_pos + 1) % FT;
    endtask

    task automatic tick();
        model_step();
        @(posedge pclk);
        #1;
        check("outs", {s_hs, s_vs, s_de, s_x, s_y, s_sol, s_sof, s_ack},
                      {e_hs, e_vs, e_de, e_x, e_y, e_sol, e_sof, e_ack});
    endtask

    initial begin
        int cyc, last_sof, last_sol, hs_lo, vs_lo, de_n, sol_n, n_ack, n_hi;
        int lo_start, last_fall, dde, dvs;
        logic prev;
        logic [22:0] snap;
        model_reset();
        #12;
        check("rst_s", {s_hs, s_vs, s_de, s_x, s_y, s_sol, s_sof, s_ack}, {2'b11, 24'd0});
        check("rst_d", {d_hs, d_vs, d_de, d_x, d_y, d_sol, d_sof, d_ack}, {2'b11, 24'd0});
        #9 reset_n = 1'b1;
        enable = 1'b1;

        cyc = 0; last_sof = -1; last_sol = -1; hs_lo = 0; vs_lo = 0; de_n = 0; sol_n = 0;
        repeat (2 * FT) begin
            tick();
            cyc++;
            if (cyc == 1) check("first_sof", {s_sof, s_sol, s_de}, 3'b111);
            hs_lo += int'(!s_hs);
            vs_lo += int'(!s_vs);
            de_n += int'(s_de);
            if (s_sof) begin
                if (last_sof >= 0) check("sof_gap", cyc - last_sof, FT);
                last_sof = cyc;
            end
            if (s_sol) begin
                if (last_sol >= 0) check("sol_gap", cyc - last_sol, HT);
                last_sol = cyc;
                sol_n++;
            end
        end
        check("hs_low", hs_lo, 2 * VT * HS);
        check("vs_low", vs_lo, 2 * VS * HT);
        check("de_cnt", de_n, 2 * HA * VA);
        check("sol_cnt", sol_n, 2 * VT);

        repeat (2 * HT + 3) tick();
        hs_pol = 1'b1;
        n_ack = 0; hs_lo = 0;
        for (int n = 0; n < 200 && !s_sof; n++) begin
            tick();
            n_ack += int'(s_ack);
            if (!s_sof && !s_hs) hs_lo++;
        end
        check("pol_sof_seen", s_sof, 1);
        check("ack_at_sof", s_ack, 1);
        check("hs_low_old_pol", hs_lo, 6 * HS);
        n_hi = 0;
        repeat (FT - 1) begin
            tick();
            n_ack += int'(s_ack);
            n_hi += int'(s_hs);
        end
        check("ack_once", n_ack, 1);
        check("hs_high_new_pol", n_hi, VT * HS);

        for (int n = 0; n < 200 && !(s_de && s_x == 10'd6); n++) tick();
        check("pause_at_x6", {s_de, s_x}, {1'b1, 10'd6});
        snap = {s_hs, s_vs, s_de, s_x, s_y};
        enable = 1'b0;
        repeat (5) begin
            tick();
            check("hold", {s_hs, s_vs, s_de, s_x, s_y}, snap);
            check("hold_strobes", {s_sol, s_sof, s_ack}, 3'b000);
        end
        enable = 1'b1;
        tick();
        check("resume_x", s_x, 7);

        repeat (600) begin
            enable = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 39) == 0) hs_pol = 1'($urandom);
            if ($urandom_range(0, 39) == 0) vs_pol = 1'($urandom);
            tick();
        end

        enable = 1'b1;
        hs_pol = 1'b0;
        vs_pol = 1'b0;
        for (int n = 0; n < 400 && m_pos != 6 * HT + 9; n++) tick();
        check("at_h9_v6", m_pos, 6 * HT + 9);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_s", {s_hs, s_vs, s_de, s_x, s_y, s_sol, s_sof, s_ack},
                             {e_hs, e_vs, e_de, e_x, e_y, e_sol, e_sof, e_ack});
        check("async_rst_d", {d_hs, d_vs, d_de, d_x, d_y, d_sol, d_sof, d_ack}, {2'b11, 24'd0});
        @(posedge pclk);
        #1;
        check("rst_hold", {s_hs, s_vs, s_de, s_sol, s_sof}, 5'b11000);
        reset_n = 1'b1;

        cyc = 0; prev = 1'b1; lo_start = -1; last_fall = -1; dde = 0; dvs = 0;
        repeat (2400) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check("post_rst_sof", {s_sof, s_x, s_y}, {1'b1, 20'd0});
                check("post_rst_dsof", {d_sof, d_x, d_y}, {1'b1, 20'd0});
            end
            if (prev && !d_hs) begin
                if (last_fall >= 0) check("dhs_period", cyc - last_fall, 800);
                last_fall = cyc;
                lo_start = cyc;
            end
            if (!prev && d_hs && lo_start >= 0) check("dhs_pulse", cyc - lo_start, 96);
            prev = d_hs;
            dde += int'(d_de);
            dvs += int'(!d_vs);
        end
        check("dhs_last_fall", last_fall, 2 * 800 + 656 + 1);
        check("dde_cnt", dde, 3 * 640);
        check("dvs_low", dvs, 0);
        check("d_strobes", {d_ack, d_sol}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
